// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the fetch front end.
// The word type, the fetch queue entry and helpers used by the fetch logic.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam word_t WORD_BYTES = 32'd4;

    // Instruction fetches are always word aligned; the low address bits are dropped.
    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(32'h3);
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundles the instruction cache, redirect/halt control and decode handshakes of the fetch front end.
// master = fetch unit; slave = its environment (cache, execute, decode).
interface ifetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    import cpu_types_pkg::*;

    // instruction cache side
    logic             ihit;
    word_t            imemload;
    logic             imemREN;
    word_t            imemaddr;

    // redirect / stall control from later stages
    logic             redirect;
    word_t            redirect_pc;
    logic             halt;

    // decode side
    logic             inst_ready;
    logic             inst_valid;
    word_t            inst;
    word_t            inst_pc;
    word_t            inst_npc;
    logic [CNT_W-1:0] count;

    modport master (
        input  ihit, imemload, redirect, redirect_pc, halt, inst_ready,
        output imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc, count
    );

    modport slave (
        output ihit, imemload, redirect, redirect_pc, halt, inst_ready,
        input  imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc, count
    );

endinterface

// File: rtl/ifq_fifo.sv
// Purpose: generic in-order synchronous FIFO with flush; owns pointers, occupancy and storage.
// Latency: a push is visible at the head the following cycle; head is read combinationally.
// Backpressure: full/head_vld reflect the registered count; pushes while full and pops while empty are dropped.
module ifq_fifo #(
    parameter int  DEPTH = 4,
    parameter int  CNT_W = $clog2(DEPTH) + 1,
    parameter type T     = logic [63:0]
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             push,
    input  T                 push_dat,
    input  logic             pop,
    output logic             head_vld,
    output T                 head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign head_vld = (count != '0);

    // Flush wins over both ports so nothing from the flushed stream survives.
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & head_vld & ~flush;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset; head_vld qualifies every read.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    a_count_bound: assert property (@(posedge CLK) disable iff (RST) count <= FULL_CNT);
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST || flush) !(push && full));

endmodule

// File: rtl/ifetch_queue.sv
// Purpose: fetch front end; owns the fetch PC, gates cache requests, queues {pc, instr} for decode, handles redirect.
// Latency: a hit in cycle N is at the queue head (inst_valid) in cycle N+1 when the queue was empty.
// Backpressure: imemREN drops when the registered count is full (one bubble after a pop), on halt, redirect or reset.
module ifetch_queue
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    DEPTH   = 4,
    parameter int    CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic CLK,
    input  logic RST,
    ifetch_queue_if.master bus
);

    word_t            pc;
    logic             full;
    logic             req;
    logic             push;
    logic             pop;
    logic             head_vld;
    fetch_entry_t     head;
    fetch_entry_t     wr_entry;
    logic [CNT_W-1:0] count;

    // Gating uses only registered state and control inputs, never ihit, so
    // the address->hit path through the cache cannot form a loop.
    assign req      = ~RST & ~bus.redirect & ~bus.halt & ~full;
    assign push     = req & bus.ihit;
    assign pop      = head_vld & bus.inst_ready;
    assign wr_entry = '{pc: pc, instr: bus.imemload};

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc <= word_align(PC_INIT);
        end else if (bus.redirect) begin
            pc <= word_align(bus.redirect_pc);
        end else if (push) begin
            pc <= pc + WORD_BYTES;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .T     (fetch_entry_t)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (bus.redirect),
        .push     (push),
        .push_dat (wr_entry),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head),
        .count    (count),
        .full     (full)
    );

    assign bus.imemREN    = req;
    assign bus.imemaddr   = pc;
    assign bus.inst_valid = head_vld;
    assign bus.count      = count;

    // Empty head presents a clean idle pattern rather than stale storage.
    assign bus.inst     = head_vld ? head.instr : '0;
    assign bus.inst_pc  = head_vld ? head.pc : '0;
    assign bus.inst_npc = head_vld ? (head.pc + WORD_BYTES) : WORD_BYTES;

    a_pc_aligned:   assert property (@(posedge CLK) disable iff (RST) pc[1:0] == 2'b00);
    a_redir_flush:  assert property (@(posedge CLK) disable iff (RST) bus.redirect |=> (count == '0));
    a_no_req_full:  assert property (@(posedge CLK) disable iff (RST) full |-> !bus.imemREN);

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: cache model, {pc,instr} scoreboard and per-scenario checks.
module tb_ifetch_queue;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h40;
    localparam int    DEPTH   = 4;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_pass   = 0;

    word_t        m_pc;
    fetch_entry_t sb[$];

    ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

    ifetch_queue #(
        .PC_INIT (PC_INIT),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic word_t mem_word(input word_t a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imemload = mem_word(bus.imemaddr);

    // One clock: sample at negedge, advance the model, compare popped entries, return 1ns after posedge.
    task automatic tick();
        fetch_entry_t e;
        logic         req;
        @(negedge CLK);
        req = !RST && !bus.redirect && !bus.halt && (sb.size() != DEPTH);
        if (!RST && sb.size() == 0) begin
            n_checks++;
            if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_npc !== 32'h4)
                $display("FAIL sb_idle: got v=%b inst=%h pc=%h npc=%h want v=0 inst=0 pc=0 npc=4",
                         bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_npc);
            else n_pass++;
        end
        if (RST) begin
            sb.delete();
            m_pc = PC_INIT;
        end else if (bus.redirect) begin
            sb.delete();
            m_pc = bus.redirect_pc & ~32'h3;
        end else begin
            if (sb.size() != 0 && bus.inst_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.inst_valid !== 1'b1 || bus.inst !== e.instr || bus.inst_pc !== e.pc || bus.inst_npc !== e.pc + 32'd4)
                    $display("FAIL sb_pop: got v=%b inst=%h pc=%h npc=%h want v=1 inst=%h pc=%h npc=%h",
                             bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_npc, e.instr, e.pc, e.pc + 32'd4);
                else n_pass++;
            end
            if (req && bus.ihit) begin
                sb.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0; bus.halt = 1'b1; #1;
        n_checks++; if (bus.imemREN !== 1'b0) $display("FAIL reset_halt_ren: got %b want 0", bus.imemREN); else n_pass++;
        bus.halt = 1'b0; #1;
        n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", bus.inst); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_npc !== 32'h4) $display("FAIL reset_inst_npc: got %h want 4", bus.inst_npc); else n_pass++;
        n_checks++; if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else n_pass++;
        n_checks++; if (bus.imemREN !== 1'b1) $display("FAIL reset_ren: got %b want 1", bus.imemREN); else n_pass++;
        n_checks++; if (bus.imemaddr !== 32'h40) $display("FAIL reset_addr: got %h want 40", bus.imemaddr); else n_pass++;
    endtask

    task automatic test_stream();
        bus.ihit = 1'b1; bus.inst_ready = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.imemaddr !== PC_INIT + word_t'(4 * i))
                $display("FAIL stream_addr: got %h want %h", bus.imemaddr, PC_INIT + word_t'(4 * i));
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (bus.inst_pc !== PC_INIT + word_t'(4 * (i - 1)) || bus.inst_npc !== PC_INIT + word_t'(4 * i))
                    $display("FAIL stream_head: got pc=%h npc=%h want pc=%h npc=%h", bus.inst_pc, bus.inst_npc,
                             PC_INIT + word_t'(4 * (i - 1)), PC_INIT + word_t'(4 * i));
                else n_pass++;
                n_checks++; if (bus.count !== 3'd1) $display("FAIL stream_count: got %0d want 1", bus.count); else n_pass++;
            end
            tick();
        end
        bus.ihit = 1'b0;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_full();
        RST = 1'b1;
        tick();
        RST = 1'b0; bus.ihit = 1'b1; bus.inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (bus.count !== 3'd4) $display("FAIL full_count: got %0d want 4", bus.count); else n_pass++;
        n_checks++; if (bus.imemREN !== 1'b0) $display("FAIL full_ren: got %b want 0", bus.imemREN); else n_pass++;
        n_checks++; if (bus.imemaddr !== 32'h50) $display("FAIL full_pc: got %h want 50", bus.imemaddr); else n_pass++;
        tick();
        n_checks++; if (bus.count !== 3'd4) $display("FAIL full_hold: got %0d want 4", bus.count); else n_pass++;
        bus.inst_ready = 1'b1; #1;
        n_checks++; if (bus.imemREN !== 1'b0) $display("FAIL full_pop_bubble: got %b want 0", bus.imemREN); else n_pass++;
        tick();
        bus.inst_ready = 1'b0; #1;
        n_checks++; if (bus.count !== 3'd3) $display("FAIL full_after_pop: got %0d want 3", bus.count); else n_pass++;
        n_checks++; if (bus.imemREN !== 1'b1) $display("FAIL full_ren_back: got %b want 1", bus.imemREN); else n_pass++;
        bus.ihit = 1'b0; bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (bus.count !== 3'd0) $display("FAIL full_drain: got %0d want 0", bus.count); else n_pass++;
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_miss();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.ihit = 1'b0;
        tick();
        bus.redirect = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.imemREN !== 1'b1 || bus.imemaddr !== 32'h100 || bus.count !== 3'd0)
                $display("FAIL miss_wait: got ren=%b addr=%h cnt=%0d want ren=1 addr=100 cnt=0",
                         bus.imemREN, bus.imemaddr, bus.count);
            else n_pass++;
            tick();
        end
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        n_checks++; if (bus.count !== 3'd1) $display("FAIL miss_count: got %0d want 1", bus.count); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'h100) $display("FAIL miss_pc: got %h want 100", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.imemaddr !== 32'h104) $display("FAIL miss_next: got %h want 104", bus.imemaddr); else n_pass++;
        tick();
        n_checks++; if (bus.count !== 3'd1) $display("FAIL miss_once: got %0d want 1", bus.count); else n_pass++;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_redirect();
        word_t disc;
        bus.ihit = 1'b1; bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (bus.count !== 3'd3) $display("FAIL redir_fill: got %0d want 3", bus.count); else n_pass++;
        disc = mem_word(m_pc);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h207; bus.inst_ready = 1'b1;
        tick();
        bus.redirect = 1'b0; bus.ihit = 1'b0; bus.inst_ready = 1'b0; #1;
        n_checks++; if (bus.count !== 3'd0) $display("FAIL redir_count: got %0d want 0", bus.count); else n_pass++;
        n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.imemaddr !== 32'h204) $display("FAIL redir_addr: got %h want 204", bus.imemaddr); else n_pass++;
        bus.ihit = 1'b1; bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.inst === disc) $display("FAIL redir_discard: got %h want anything else", bus.inst); else n_pass++;
            tick();
        end
        bus.ihit = 1'b0;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0; bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        n_checks++; if (bus.inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffc", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_npc !== 32'h0) $display("FAIL wrap_npc: got %h want 0", bus.inst_npc); else n_pass++;
        n_checks++; if (bus.imemaddr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", bus.imemaddr); else n_pass++;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_halt();
        bus.ihit = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.count !== 3'd2) $display("FAIL halt_fill: got %0d want 2", bus.count); else n_pass++;
        bus.halt = 1'b1; bus.inst_ready = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.imemREN !== 1'b0 || bus.imemaddr !== 32'h8)
                $display("FAIL halt_frozen: got ren=%b addr=%h want ren=0 addr=8", bus.imemREN, bus.imemaddr);
            else n_pass++;
            tick();
        end
        n_checks++; if (bus.count !== 3'd0) $display("FAIL halt_drain: got %0d want 0", bus.count); else n_pass++;
        bus.halt = 1'b0; #1;
        n_checks++;
        if (bus.imemREN !== 1'b1 || bus.imemaddr !== 32'h8)
            $display("FAIL halt_resume: got ren=%b addr=%h want ren=1 addr=8", bus.imemREN, bus.imemaddr);
        else n_pass++;
        bus.inst_ready = 1'b0;
        tick();
        n_checks++; if (bus.inst_pc !== 32'h8) $display("FAIL halt_resume_pc: got %h want 8", bus.inst_pc); else n_pass++;
        bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
        tick();
        bus.redirect = 1'b0; #1;
        n_checks++;
        if (bus.imemaddr !== 32'h300 || bus.imemREN !== 1'b0 || bus.count !== 3'd0)
            $display("FAIL halt_redirect: got addr=%h ren=%b cnt=%0d want addr=300 ren=0 cnt=0",
                     bus.imemaddr, bus.imemREN, bus.count);
        else n_pass++;
        bus.halt = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.count !== 3'd2) $display("FAIL rst_prefill: got %0d want 2", bus.count); else n_pass++;
        RST = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h500;
        tick();
        RST = 1'b0; bus.redirect = 1'b0; bus.ihit = 1'b0; #1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.inst_valid !== 1'b0 || bus.imemaddr !== 32'h40 || bus.inst_npc !== 32'h4 || bus.imemREN !== 1'b1)
            $display("FAIL rst_mid: got cnt=%0d v=%b addr=%h npc=%h ren=%b want cnt=0 v=0 addr=40 npc=4 ren=1",
                     bus.count, bus.inst_valid, bus.imemaddr, bus.inst_npc, bus.imemREN);
        else n_pass++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        bus.ihit = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt = 1'b0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_miss();
        test_redirect();
        test_wrap();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
